// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operating-mode encodings.
package usr_pkg;

  typedef enum logic [2:0] {
    OP_PISO = 3'd0,
    OP_SIPO = 3'd1,
    OP_PIPO = 3'd2,
    OP_SISO = 3'd3,
    OP_ROR  = 3'd4,
    OP_ROL  = 3'd5,
    OP_SHL  = 3'd6,
    OP_SHR  = 3'd7
  } usr_op_e;

endpackage

// File: rtl/usr.sv
// Universal N-bit shift register: parallel/serial load, shifts and rotates
// selected by op, with a serial output tapped from the appropriate end.
module usr
  import usr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   op,
  input  logic         load,
  input  logic [N-1:0] i,
  input  logic         in,
  output logic [N-1:0] q,
  output logic         out
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic [N-1:0] shr_in;
  usr_op_e      op_sel;

  assign op_sel = usr_op_e'(op);
  assign shr_in = {in, q_q[N-1:1]};

  always_comb begin
    q_d = q_q;
    unique case (op_sel)
      OP_PISO: q_d = load ? i : {1'b0, q_q[N-1:1]};
      OP_SIPO: q_d = load ? shr_in : q_q;
      OP_PIPO: q_d = load ? i : q_q;
      OP_SISO: q_d = shr_in;
      OP_ROR:  q_d = load ? i : {q_q[0], q_q[N-1:1]};
      OP_ROL:  q_d = load ? i : {q_q[N-2:0], q_q[N-1]};
      OP_SHL:  q_d = load ? i : {q_q[N-2:0], in};
      OP_SHR:  q_d = load ? i : shr_in;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  // Left-moving modes emit from the MSB; everything else emits the LSB.
  always_comb begin
    out = q_q[0];
    if (op_sel == OP_ROL || op_sel == OP_SHL) out = q_q[N-1];
  end

  assign q = q_q;

endmodule

// File: tb/tb_usr.sv
// Directed, table-driven bench for usr with N=4; expectations hand-computed.
module tb_usr;

  logic       clk;
  logic       rst;
  logic [2:0] op;
  logic       load;
  logic [3:0] i;
  logic       in;
  logic [3:0] q;
  logic       out;

  int total;
  int bad;

  typedef struct {
    logic       rst;
    logic [2:0] op;
    logic       load;
    logic [3:0] i;
    logic       in;
    logic [3:0] exp_q;
    logic       exp_out;
  } vec_t;

  vec_t vecs[$];

  usr #(.N(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .op   (op),
    .load (load),
    .i    (i),
    .in   (in),
    .q    (q),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [3:0] exp_q, input logic exp_out);
    total++;
    if (q !== exp_q) begin
      bad++;
      $display("FAIL %s: q actual=%b required=%b", name, q, exp_q);
    end
    total++;
    if (out !== exp_out) begin
      bad++;
      $display("FAIL %s: out actual=%b required=%b", name, out, exp_out);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] o, input logic l,
                      input logic [3:0] ii, input logic s);
    rst = r; op = o; load = l; i = ii; in = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0; op = 3'd0; load = 1'b0; i = '0; in = 1'b0;

    //            rst op    ld  i        in   q        out
    vecs.push_back('{1'b0, 3'd3, 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0});
    // PISO
    vecs.push_back('{1'b1, 3'd0, 1'b1, 4'b1001, 1'b0, 4'b1001, 1'b1});
    vecs.push_back('{1'b1, 3'd0, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1});
    vecs.push_back('{1'b1, 3'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0});
    // SIPO
    vecs.push_back('{1'b1, 3'd1, 1'b1, 4'b0110, 1'b1, 4'b1000, 1'b0});
    vecs.push_back('{1'b1, 3'd1, 1'b1, 4'b0110, 1'b0, 4'b0100, 1'b0});
    vecs.push_back('{1'b1, 3'd1, 1'b1, 4'b0110, 1'b0, 4'b0010, 1'b0});
    vecs.push_back('{1'b1, 3'd1, 1'b1, 4'b0110, 1'b1, 4'b1001, 1'b1});
    vecs.push_back('{1'b1, 3'd1, 1'b0, 4'b0110, 1'b0, 4'b1001, 1'b1});
    vecs.push_back('{1'b1, 3'd1, 1'b0, 4'b0110, 1'b1, 4'b1001, 1'b1});
    // ROR
    vecs.push_back('{1'b1, 3'd4, 1'b1, 4'b1001, 1'b0, 4'b1001, 1'b1});
    vecs.push_back('{1'b1, 3'd4, 1'b0, 4'b0000, 1'b0, 4'b1100, 1'b0});
    vecs.push_back('{1'b1, 3'd4, 1'b0, 4'b0000, 1'b0, 4'b0110, 1'b0});
    vecs.push_back('{1'b1, 3'd4, 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b1});
    vecs.push_back('{1'b1, 3'd4, 1'b0, 4'b0000, 1'b0, 4'b1001, 1'b1});
    // ROL
    vecs.push_back('{1'b1, 3'd5, 1'b1, 4'b1001, 1'b0, 4'b1001, 1'b1});
    vecs.push_back('{1'b1, 3'd5, 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b0});
    vecs.push_back('{1'b1, 3'd5, 1'b0, 4'b0000, 1'b0, 4'b0110, 1'b0});
    vecs.push_back('{1'b1, 3'd5, 1'b0, 4'b0000, 1'b0, 4'b1100, 1'b1});
    vecs.push_back('{1'b1, 3'd5, 1'b0, 4'b0000, 1'b0, 4'b1001, 1'b1});
    // SHL, in=0
    vecs.push_back('{1'b1, 3'd6, 1'b1, 4'b1001, 1'b0, 4'b1001, 1'b1});
    vecs.push_back('{1'b1, 3'd6, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 1'b0, 4'b0000, 1'b0, 4'b1000, 1'b1});
    vecs.push_back('{1'b1, 3'd6, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0});
    // SHR, in=0
    vecs.push_back('{1'b1, 3'd7, 1'b1, 4'b1001, 1'b0, 4'b1001, 1'b1});
    vecs.push_back('{1'b1, 3'd7, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0});
    vecs.push_back('{1'b1, 3'd7, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0});
    vecs.push_back('{1'b1, 3'd7, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b1});
    vecs.push_back('{1'b1, 3'd7, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0});
    // PIPO load then hold
    vecs.push_back('{1'b1, 3'd2, 1'b1, 4'b1001, 1'b0, 4'b1001, 1'b1});
    vecs.push_back('{1'b1, 3'd2, 1'b0, 4'b0110, 1'b1, 4'b1001, 1'b1});
    // SISO shifts regardless of load; i ignored
    vecs.push_back('{1'b1, 3'd3, 1'b0, 4'b0000, 1'b1, 4'b1100, 1'b0});
    vecs.push_back('{1'b1, 3'd3, 1'b1, 4'b1111, 1'b0, 4'b0110, 1'b0});
    // SHL / SHR with in=1
    vecs.push_back('{1'b1, 3'd6, 1'b0, 4'b0000, 1'b1, 4'b1101, 1'b1});
    vecs.push_back('{1'b1, 3'd7, 1'b0, 4'b0000, 1'b1, 4'b1110, 1'b0});
    // Reset overrides a parallel load
    vecs.push_back('{1'b0, 3'd2, 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0});

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].op, vecs[k].load, vecs[k].i, vecs[k].in);
      check($sformatf("vec%0d", k), vecs[k].exp_q, vecs[k].exp_out);
    end

    // Mid-rotate reset, then resume from zero
    step(1'b1, 3'd4, 1'b1, 4'b1001, 1'b0);
    check("ror_load", 4'b1001, 1'b1);
    step(1'b1, 3'd4, 1'b0, 4'b0000, 1'b0);
    check("ror_step", 4'b1100, 1'b0);
    step(1'b0, 3'd4, 1'b0, 4'b0000, 1'b0);
    check("ror_midreset", 4'b0000, 1'b0);
    step(1'b1, 3'd4, 1'b0, 4'b0000, 1'b1);
    check("ror_after_reset1", 4'b0000, 1'b0);
    step(1'b1, 3'd4, 1'b0, 4'b0000, 1'b1);
    check("ror_after_reset2", 4'b0000, 1'b0);

    // out mux follows op combinationally, before any edge
    step(1'b1, 3'd2, 1'b1, 4'b1000, 1'b0);
    check("pipo_1000", 4'b1000, 1'b0);
    op = 3'd5;
    #1;
    check("out_mux_rol", 4'b1000, 1'b1);
    op = 3'd6;
    #1;
    check("out_mux_shl", 4'b1000, 1'b1);
    op = 3'd4;
    #1;
    check("out_mux_ror", 4'b1000, 1'b0);
    // op change takes effect on the next edge: ROL from 1000
    step(1'b1, 3'd5, 1'b0, 4'b0000, 1'b0);
    check("rol_after_change", 4'b0001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usr.md
USR -- requirements
Module: usr

Interface
REQ-001 Parameter N, default 4, SHALL set register width; legal N >= 2.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-low.
REQ-004 op  input  3  SHALL select the operating mode.
REQ-005 load  input  1  SHALL be the parallel-load / serial-capture enable.
REQ-006 i  input  N  SHALL be the parallel data input.
REQ-007 in  input  1  SHALL be the serial data / fill bit.
REQ-008 q  output  N  SHALL be the register contents, driven directly from the state register.
REQ-009 out  output  1  SHALL be the serial output bit.

Function
REQ-010 Op encoding SHALL be: 0 PISO, 1 SIPO, 2 PIPO, 3 SISO, 4 ROR, 5 ROL, 6 SHL, 7 SHR.
REQ-011 Serial-in shifts (SIPO, SISO, SHR) SHALL move right: q <= {in, q[N-1:1]}, with in entering the MSB.
REQ-012 PISO: load=1 -> q <= i; load=0 -> q <= {0, q[N-1:1]} (shift out LSB first, zero fill).
REQ-013 SIPO: load=1 -> serial right shift per REQ-011; load=0 -> hold.
REQ-014 PIPO: load=1 -> q <= i; load=0 -> hold.
REQ-015 SISO: serial right shift per REQ-011 every cycle, regardless of load.
REQ-016 ROR: load=1 -> q <= i; load=0 -> q <= {q[0], q[N-1:1]}.
REQ-017 ROL: load=1 -> q <= i; load=0 -> q <= {q[N-2:0], q[N-1]}.
REQ-018 SHL: load=1 -> q <= i; load=0 -> q <= {q[N-2:0], in}.
REQ-019 SHR: load=1 -> q <= i; load=0 -> serial right shift per REQ-011.
REQ-020 out SHALL be combinational from q: q[N-1] when op is ROL or SHL, otherwise q[0].
REQ-021 Latency SHALL be one clock for every operation; the new q is visible after the capturing edge.
REQ-022 An op change SHALL take effect on the next edge; no state other than q is kept.

Reset
REQ-023 When rst=0 at a rising edge, q SHALL become all zeros, and therefore out=0, regardless of op, load, i or in.
REQ-024 Reset SHALL override any in-progress shift or rotate; operation resumes from zero on the first edge with rst=1.
REQ-025 Between time zero and the first reset edge, q is undefined; benches SHALL apply reset first.

Structure
REQ-026 The op encodings (REQ-010) SHALL be named constants in a shared package, usr_pkg.
REQ-027 The design SHALL be a single module with one clocked next-state block and one combinational out mux; no sub-module.

Verification (N=4)
REQ-028 Reset: rst=0 for one edge during any op -> q=0000, out=0.
REQ-029 PISO: op=0, load=1, i=1001 -> q=1001, out=1; then load=0 -> q=0100, 0010, 0001, 0000 with out=0, 0, 1, 0.
REQ-030 SIPO: from 0000, op=1, load=1, in=1,0,0,1 on successive edges -> q=1000, 0100, 0010, 1001; then load=0 -> q holds 1001.
REQ-031 Rotates: load 1001 then load=0. ROR -> 1100, 0110, 0011, 1001. ROL -> 0011, 0110, 1100, 1001.
REQ-032 Shifts with in=0: load 1001 then load=0. SHL -> 0010, 0100, 1000, 0000. SHR -> 0100, 0010, 0001, 0000. PIPO with load=0 -> holds 1001.
REQ-033 Mid-operation reset: during ROR, take rst low -> next q=0000; rst high with load=0 -> q stays 0000.
